load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access stage that sits directly downstream of the ALU. It takes the ALU's computed effective address, the instruction's funct3 and the store operand, and runs a req/ack transaction on the data-memory port. For loads it returns a lane-selected, sign- or zero-extended result for register writeback. It also reports misaligned, illegal-funct3 and timed-out accesses as a fault without touching memory.

## Interface
- WIDTH, 32: datapath width; only 32 is supported, since lane logic assumes 4 bytes.
- TIMEOUT, 255: maximum cycles mem_req stays high without mem_ack before the access faults; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse from control; sampled only when busy=0.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
- addr  in  WIDTH  effective address (ALU output).
- wdata  in  WIDTH  store operand (rs2).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  high only together with done; the access did not complete.
- rdata  out  WIDTH  extended load result; holds until the next successful load.
- mem_req  out  1  memory request; held until acknowledged or timed out.
- mem_we  out  1  write enable for the current request.
- mem_addr  out  WIDTH  word-aligned address {addr[WIDTH-1:2],2'b00}.
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables for the accessed lanes.
- mem_ack  in  1  memory completion; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  WIDTH  read word.

## Operation
- States are IDLE, REQ, DONE and FAULT. Reset enters IDLE.
- Reset values: all outputs are 0 and the timeout counter is 0.
- **IDLE:** on start=1, latch we, funct3, addr and wdata, then classify the access.
  - Illegal funct3 (load 011/110/111; store ≥011) → FAULT.
  - Misaligned address (half with addr[0]=1; word with addr[1:0]≠0) → FAULT.
  - Otherwise → REQ.
- **REQ:** mem_req=1; mem_we, mem_addr, mem_wdata and mem_be are driven from the latched values and stay stable.
  - The counter increments on each cycle without mem_ack.
  - mem_ack=1 → DONE. For a load, register the extended result into rdata in the same edge.
  - No ack when counter = TIMEOUT-1 → FAULT. An ack in that final cycle wins over the timeout.
- **DONE:** done=1 for one cycle, then IDLE.
- **FAULT:** done=1 and fault=1 for one cycle, then IDLE. rdata is unchanged and memory is never requested.
- Byte enables (mem_be):
  - Byte access: 1<<addr[1:0].
  - Half access: 0011 or 1100, selected by addr[1].
  - Word access: 1111.
- Store data (mem_wdata):
  - Byte: the low byte replicated ×4.
  - Half: the low half replicated ×2.
  - Word: passed through.
- Load extraction: select the addressed lane from mem_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores never modify rdata.
- start while busy=1 is ignored. mem_ack outside REQ is ignored.
- Reset asserted mid-access clears the state immediately: mem_req drops asynchronously and no done is issued.

## Timing
- start sampled at edge 0 → mem_req high from cycle 1.
- mem_ack in cycle k (k≥1) → done in cycle k+1; mem_req is low in cycle k+1.
- rdata is valid from cycle k+1. Minimum latency from start to done is 2 cycles.
- Fault on classification: done=fault=1 in cycle 1, and mem_req never rises.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then done=fault=1 in the following cycle.
- busy is high from cycle 1 through the done cycle inclusive. The earliest next start is accepted in the cycle after done.
- All outputs are registered; none depends combinationally on start or mem_ack.

## Structure
- Shared package/include holds:
  - funct3 load/store encodings;
  - state encoding;
  - the default TIMEOUT;
  - the byte-enable width constant.
- Timeout counter width is $clog2(TIMEOUT+1).
- Sub-module load_extend: combinational lane select plus sign/zero extension, driven by (mem_rdata, addr[1:0], funct3). It is reused by any later writeback stage.

## Test plan
- **LW addr 0x100; memory acks 3 cycles after mem_req with 0xDEADBEEF:**
  - mem_addr=0x100, mem_be=1111;
  - done 1 cycle after ack, rdata=0xDEADBEEF, fault=0.
- **LB/LBU/LH/LHU at addr 0x203, 0x202, 0x201 over word 0x80FF7F01:**
  - LB 0x203 → 0xFFFFFF80.
  - LBU 0x203 → 0x00000080.
  - LH 0x202 → 0xFFFF80FF.
  - LH 0x201 → fault, mem_req never rises.
- **SB 0x1A5 to addr 0x302:** mem_wdata=0xA5A5A5A5, mem_be=0100, mem_we=1; rdata unchanged.
- **SH to addr 0x301:** done=fault=1 in cycle 1 with no request. **funct3=011 load:** fault.
- **TIMEOUT=4 with no ack:** mem_req high 4 cycles, then done=fault=1. **Repeat with ack in the 4th cycle:** completes normally.
- **Reset and start interactions:**
  - rst_n pulled low 2 cycles into REQ: mem_req falls immediately, no done.
  - After release: start accepted normally.
  - start pulses while busy: ignored, no extra transactions.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Purpose: shared encodings and access helpers for the load/store unit and its writeback users.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

    localparam int BE_W            = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    // funct3 encodings; loads and stores share 000/001/010 for byte/half/word
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    // Legal encoding for the direction and naturally aligned for its size.
    function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] lane);
        logic legal;
        logic aligned;
        if (we) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3[1:0])
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

    function automatic logic [BE_W-1:0] byte_enables(input logic [2:0] f3, input logic [1:0] lane);
        logic [BE_W-1:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across all lanes so the byte enables pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3[1:0])
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Purpose: select the addressed lane of a read word and sign/zero-extend it per funct3.
// Latency: combinational.
// Backpressure: none.
// Ports: mem_rdata_i read word, lane_i addr[1:0], funct3_i access type, result_o extended value.
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic [1:0]       lane_i,
    input  logic [2:0]       funct3_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        // Bring the addressed lane down to bit 0 before extending
        shifted = mem_rdata_i >> {lane_i, 3'b000};
        case (funct3_i)
            F3_B:    result_o = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   result_o = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            F3_H:    result_o = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   result_o = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: result_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: data-memory access stage: classifies, issues req/ack access, returns extended load data.
// Latency: start->done = ack cycle + 1 (min 2); classification faults done in cycle 1; timeout after TIMEOUT req cycles.
// Backpressure: start ignored while busy; mem_req held until mem_ack or timeout.
// Ports: start/we/funct3/addr/wdata from control+ALU; busy/done/fault/rdata to pipeline;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_ack/mem_rdata to data memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [BE_W-1:0]  mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;
    logic [WIDTH-1:0] load_val;

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .mem_rdata_i (mem_rdata),
        .lane_i      (lane_q),
        .funct3_i    (f3_q),
        .result_o    (load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            lane_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        f3_q   <= funct3;
                        lane_q <= addr[1:0];
                        cnt_q  <= '0;
                        busy   <= 1'b1;
                        if (access_ok(we, funct3, addr[1:0])) begin
                            state_q   <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= we;
                            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                            mem_wdata <= store_lanes(funct3, wdata);
                            mem_be    <= byte_enables(funct3, addr[1:0]);
                        end else begin
                            // Rejected before memory is ever requested
                            state_q <= ST_FAULT;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so an ack in the last allowed cycle still completes
                    if (mem_ack) begin
                        state_q <= ST_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            rdata <= load_val;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= ST_FAULT;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rdata = 32'h0;

    load_store_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          got;
        logic        fault;
        int          done_cyc;
        int          req;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wd;
        logic        mwe;
        bit          stable;
        bit          busy_ok;
        bit          after_ok;
        logic        req_in_done;
        logic [31:0] rdata;
    } obs_t;

    typedef struct {
        logic        fault;
        int          done_cyc;
        int          req;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wd;
        logic [31:0] rdata;
    } exp_t;

    // Reference: what an access should look like, from sizes, lanes and cycle counts.
    function automatic exp_t model(input logic m_we, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input int ack_at, input logic [31:0] word,
                                   input logic [31:0] old);
        exp_t        e;
        int          size;
        int          lane;
        bit          legal;
        logic [31:0] v;
        logic [31:0] mask;
        size  = 1 << f3[1:0];
        lane  = int'(a[1:0]);
        legal = m_we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.be  = 4'(((1 << size) - 1) << lane);
        e.maddr = {a[31:2], 2'b00};
        e.wd  = 32'h0;
        for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v    = (word >> (8 * lane)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        if (!legal || (lane % size) != 0) begin
            e.fault = 1'b1; e.done_cyc = 1; e.req = 0; e.rdata = old;
        end else if (ack_at <= TO) begin
            e.fault = 1'b0; e.done_cyc = ack_at + 1; e.req = ack_at; e.rdata = m_we ? old : v;
        end else begin
            e.fault = 1'b1; e.done_cyc = TO + 1; e.req = TO; e.rdata = old;
        end
        return e;
    endfunction

    // Drives one access and plays memory: ack in the ack_at-th cycle of mem_req.
    task automatic do_access(input logic a_we, input logic [2:0] a_f3, input logic [31:0] a_addr,
                             input logic [31:0] a_wd, input int ack_at, input logic [31:0] word,
                             input bit hold_start, output obs_t o);
        int req;
        bit fin;
        o.got = 0; o.fault = 0; o.done_cyc = 0; o.req = 0; o.be = 0; o.maddr = 0; o.wd = 0;
        o.mwe = 0; o.stable = 1; o.busy_ok = 1; o.after_ok = 0; o.req_in_done = 0; o.rdata = 0;
        req = 0;
        fin = 0;
        @(posedge clk); #1;
        start = 1'b1; we = a_we; funct3 = a_f3; addr = a_addr; wdata = a_wd;
        @(posedge clk); #1;
        start = hold_start; we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 20 && !fin; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (busy !== 1'b1) o.busy_ok = 0;
            if (done === 1'b1) begin
                fin = 1; o.got = 1; o.done_cyc = c; o.fault = fault; o.rdata = rdata;
                o.req_in_done = mem_req; start = 1'b0;
            end else if (mem_req === 1'b1) begin
                req++;
                if (req == 1) begin
                    o.be = mem_be; o.maddr = mem_addr; o.wd = mem_wdata; o.mwe = mem_we;
                end else if (mem_be !== o.be || mem_addr !== o.maddr || mem_wdata !== o.wd || mem_we !== o.mwe) begin
                    o.stable = 0;
                end
                if (req == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = word;
                end
            end
            if (hold_start && !fin) begin
                we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            end
        end
        o.req = req;
        start = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        o.after_ok = (done === 1'b0 && busy === 1'b0 && mem_req === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if ({busy, done, fault, mem_req, mem_we} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, fault, mem_req, mem_we}); end
        checks++; if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {rdata, mem_addr, mem_wdata, mem_be}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_lw();
        obs_t o;
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, o);
        checks++; if (o.maddr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=%h", o.maddr, 32'h100); end
        checks++; if (o.be !== 4'hF) begin failures++; $display("FAIL lw_be got=%b exp=1111", o.be); end
        checks++; if (o.done_cyc !== 4 || o.fault !== 1'b0) begin failures++; $display("FAIL lw_done got=cyc%0d/f%b exp=cyc4/f0", o.done_cyc, o.fault); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", o.rdata); end
        checks++; if (o.req_in_done !== 1'b0 || !o.after_ok) begin failures++; $display("FAIL lw_end got=req%b/after%0d exp=req0/after1", o.req_in_done, o.after_ok); end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_lanes();
        obs_t o;
        do_access(1'b0, 3'b000, 32'h203, 32'h0, 2, 32'h80FF7F01, 1'b0, o);
        checks++; if (o.rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", o.rdata); end
        do_access(1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FF7F01, 1'b0, o);
        checks++; if (o.rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", o.rdata); end
        do_access(1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h80FF7F01, 1'b0, o);
        checks++; if (o.rdata !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff80ff", o.rdata); end
        checks++; if (o.be !== 4'b1100) begin failures++; $display("FAIL lh_be got=%b exp=1100", o.be); end
        do_access(1'b0, 3'b001, 32'h201, 32'h0, 1, 32'h12345678, 1'b0, o);
        checks++; if (o.fault !== 1'b1 || o.done_cyc !== 1 || o.req !== 0) begin failures++; $display("FAIL lh_misalign got=f%b/cyc%0d/req%0d exp=f1/cyc1/req0", o.fault, o.done_cyc, o.req); end
        checks++; if (o.rdata !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_misalign_rdata got=%h exp=ffff80ff", o.rdata); end
        exp_rdata = 32'hFFFF80FF;
    endtask

    task automatic test_store();
        obs_t o;
        do_access(1'b1, 3'b000, 32'h302, 32'h1A5, 2, 32'h55AA55AA, 1'b0, o);
        checks++; if (o.wd !== 32'hA5A5A5A5 || o.be !== 4'b0100 || o.mwe !== 1'b1) begin failures++; $display("FAIL sb_bus got=%h/%b/%b exp=a5a5a5a5/0100/1", o.wd, o.be, o.mwe); end
        checks++; if (o.rdata !== exp_rdata || o.fault !== 1'b0 || o.done_cyc !== 3) begin failures++; $display("FAIL sb_done got=%h/f%b/cyc%0d exp=%h/f0/cyc3", o.rdata, o.fault, o.done_cyc, exp_rdata); end
    endtask

    task automatic test_faults();
        obs_t o;
        do_access(1'b1, 3'b001, 32'h301, 32'hBEEF, 1, 32'h0, 1'b0, o);
        checks++; if (o.fault !== 1'b1 || o.done_cyc !== 1 || o.req !== 0) begin failures++; $display("FAIL sh_misalign got=f%b/cyc%0d/req%0d exp=f1/cyc1/req0", o.fault, o.done_cyc, o.req); end
        do_access(1'b0, 3'b011, 32'h400, 32'h0, 1, 32'h0, 1'b0, o);
        checks++; if (o.fault !== 1'b1 || o.done_cyc !== 1 || o.req !== 0) begin failures++; $display("FAIL f3_011 got=f%b/cyc%0d/req%0d exp=f1/cyc1/req0", o.fault, o.done_cyc, o.req); end
        checks++; if (o.rdata !== exp_rdata || !o.after_ok) begin failures++; $display("FAIL f3_011_rdata got=%h/after%0d exp=%h/after1", o.rdata, o.after_ok, exp_rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 99, 32'h0, 1'b0, o);
        checks++; if (o.req !== TO || o.fault !== 1'b1 || o.done_cyc !== TO + 1) begin failures++; $display("FAIL timeout got=req%0d/f%b/cyc%0d exp=req%0d/f1/cyc%0d", o.req, o.fault, o.done_cyc, TO, TO + 1); end
        checks++; if (o.rdata !== exp_rdata) begin failures++; $display("FAIL timeout_rdata got=%h exp=%h", o.rdata, exp_rdata); end
        do_access(1'b0, 3'b010, 32'h40, 32'h0, TO, 32'h0BADF00D, 1'b0, o);
        checks++; if (o.fault !== 1'b0 || o.done_cyc !== TO + 1 || o.rdata !== 32'h0BADF00D) begin failures++; $display("FAIL ack_last got=f%b/cyc%0d/%h exp=f0/cyc%0d/0badf00d", o.fault, o.done_cyc, o.rdata, TO + 1); end
        exp_rdata = 32'h0BADF00D;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   no_done;
        @(posedge clk); #1;
        start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_req_pre got=%b exp=1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL mid_reset got=req%b/busy%b/%h exp=req0/busy0/0", mem_req, busy, rdata); end
        no_done = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 0;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || mem_req !== 1'b0) no_done = 0;
        end
        checks++; if (!no_done) begin failures++; $display("FAIL mid_no_done got=done_or_req_seen exp=none"); end
        exp_rdata = 32'h0;
        do_access(1'b0, 3'b010, 32'h104, 32'h0, 2, 32'hCAFE0001, 1'b0, o);
        checks++; if (o.done_cyc !== 3 || o.fault !== 1'b0 || o.rdata !== 32'hCAFE0001) begin failures++; $display("FAIL post_reset got=cyc%0d/f%b/%h exp=cyc3/f0/cafe0001", o.done_cyc, o.fault, o.rdata); end
        exp_rdata = 32'hCAFE0001;
    endtask

    task automatic test_busy_start();
        obs_t o;
        bit   quiet;
        do_access(1'b0, 3'b010, 32'h80, 32'h0, 3, 32'h13579BDF, 1'b1, o);
        checks++; if (o.done_cyc !== 4 || o.req !== 3 || !o.stable || o.maddr !== 32'h80) begin failures++; $display("FAIL busy_start got=cyc%0d/req%0d/st%0d/%h exp=cyc4/req3/st1/00000080", o.done_cyc, o.req, o.stable, o.maddr); end
        checks++; if (o.rdata !== 32'h13579BDF || !o.after_ok) begin failures++; $display("FAIL busy_start_end got=%h/after%0d exp=13579bdf/after1", o.rdata, o.after_ok); end
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet = 0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL busy_extra got=activity exp=idle"); end
        exp_rdata = 32'h13579BDF;
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wd, r_word;
        int          r_ack;
        for (int n = 0; n < 150; n++) begin
            r_we = 1'($urandom); r_f3 = 3'($urandom); r_addr = $urandom; r_wd = $urandom;
            r_word = $urandom; r_ack = $urandom_range(1, TO + 2);
            e = model(r_we, r_f3, r_addr, r_wd, r_ack, r_word, exp_rdata);
            do_access(r_we, r_f3, r_addr, r_wd, r_ack, r_word, 1'b0, o);
            checks++; if (o.fault !== e.fault || o.done_cyc !== e.done_cyc || o.req !== e.req) begin failures++; $display("FAIL rnd%0d_flow got=f%b/cyc%0d/req%0d exp=f%b/cyc%0d/req%0d", n, o.fault, o.done_cyc, o.req, e.fault, e.done_cyc, e.req); end
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL rnd%0d_rdata we=%b f3=%b a=%h got=%h exp=%h", n, r_we, r_f3, r_addr, o.rdata, e.rdata); end
            checks++; if (!o.busy_ok || !o.after_ok || o.req_in_done !== 1'b0) begin failures++; $display("FAIL rnd%0d_hs got=busy%0d/after%0d/req%b exp=1/1/0", n, o.busy_ok, o.after_ok, o.req_in_done); end
            if (e.req > 0) begin
                checks++; if (o.be !== e.be || o.maddr !== e.maddr || o.wd !== e.wd || o.mwe !== r_we || !o.stable) begin failures++; $display("FAIL rnd%0d_bus got=%b/%h/%h/%b/st%0d exp=%b/%h/%h/%b/st1", n, o.be, o.maddr, o.wd, o.mwe, o.stable, e.be, e.maddr, e.wd, r_we); end
            end
            exp_rdata = e.rdata;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lanes();
        test_store();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_busy_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
